// File: rtl/if_ctrl.sv
// ---------------------------------------------------------------------------
// if_ctrl -- instruction fetch controller.
// Issues one instruction-memory request at a time, then waits for its
// response. It holds the fetched instruction until decode accepts it and
// handles redirects from execute, discarding any response that the redirect
// makes stale.
//
// Build option: define IF_CTRL_MISALIGN_EN so that a redirect to an address
// that is not word-aligned goes to TRAP_VEC and pulses misalign_o. Without the
// macro, the low two target bits are cleared and misalign_o is tied to 0.
// ---------------------------------------------------------------------------
module if_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

`ifdef IF_CTRL_MISALIGN_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] fetch_addr_p0;
    logic [31:0] inst_p1;
    logic [31:0] inst_pc_p1;
    logic        vld_p1;

    // Redirect target: a misaligned target traps when checking is enabled;
    // otherwise it is forced to word alignment.
    function automatic logic [31:0] redirect_target(input logic [31:0] tgt);
        if (MISALIGN_EN && (tgt[1:0] != 2'b00))
            return TRAP_VEC;
        else
            return {tgt[31:2], 2'b00};
    endfunction

    assign imem_req_o   = (state == S_REQ);
    assign imem_addr_o  = pc;
    assign pc_o         = pc;
    assign inst_valid_o = vld_p1;
    assign inst_o       = inst_p1;
    assign inst_pc_o    = inst_pc_p1;

    // Fetch FSM. Only one transaction can be outstanding, because a new
    // request is issued only from S_REQ.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_BOOT;
            pc            <= RESET_ADDR;
            fetch_addr_p0 <= 32'h0;
            inst_p1       <= 32'h0;
            inst_pc_p1    <= 32'h0;
            vld_p1        <= 1'b0;
        end else begin
            case (state)
                S_BOOT: state <= S_REQ;
                // request -> grant: the granted address moves to p0
                S_REQ: begin
                    if (redirect_i) begin
                        pc     <= redirect_target(redirect_pc_i);
                        vld_p1 <= 1'b0;
                        state  <= imem_gnt_i ? S_DRAIN : S_REQ;
                    end else if (imem_gnt_i) begin
                        fetch_addr_p0 <= pc;
                        pc            <= pc + 32'd4;
                        state         <= S_WAIT;
                    end
                end
                // grant -> response: data and its address move to p1
                S_WAIT: begin
                    if (redirect_i) begin
                        pc     <= redirect_target(redirect_pc_i);
                        vld_p1 <= 1'b0;
                        state  <= imem_rvalid_i ? S_REQ : S_DRAIN;
                    end else if (imem_rvalid_i) begin
                        inst_p1    <= imem_rdata_i;
                        inst_pc_p1 <= fetch_addr_p0;
                        vld_p1     <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                // p1 -> decode handshake
                S_HOLD: begin
                    if (redirect_i) begin
                        pc     <= redirect_target(redirect_pc_i);
                        vld_p1 <= 1'b0;
                        state  <= S_REQ;
                    end else if (inst_ready_i) begin
                        vld_p1 <= 1'b0;
                        state  <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (redirect_i)
                        pc <= redirect_target(redirect_pc_i);
                    if (imem_rvalid_i)
                        state <= S_REQ;
                end
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef IF_CTRL_MISALIGN_EN
    logic misalign_q;

    // One-cycle pulse for every accepted redirect whose target is misaligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            misalign_q <= 1'b0;
        else
            misalign_q <= (state != S_BOOT) && redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule
